// File: rtl/arm_pkg.sv
// Shared definitions for the servo PWM decoder.
// Holds the default timing constants (100 MHz clock, 0.5 ms at 0 degrees,
// 1000 cycles per degree, 180 degree full scale, 40 ms loss timeout), the
// internal counter widths and the per-channel capture FSM state encoding.
package arm_pkg;

  localparam int unsigned DUTY_GAP    = 1000;
  localparam int unsigned OFFSET_CYC  = 50000;
  localparam int unsigned MAX_DEG     = 180;
  localparam int unsigned TIMEOUT_CYC = 4000000;

  // High-time counter width; covers OFFSET_CYC + (MAX_DEG + 1) * DUTY_GAP at the defaults.
  localparam int unsigned HIGH_CNT_W = 20;
  // Decoded angle width; bits above this are tied to zero on the 32-bit outputs.
  localparam int unsigned ANGLE_W    = 8;

  typedef enum logic [2:0] {
    StIdle,
    StHigh,
    StDiv,
    StDone,
    StStuck
  } ch_state_e;

endpackage

// File: rtl/pwm_capture_ch.sv
// One servo PWM capture channel.
// Synchronizes the PWM pin, measures the high time in clock cycles, converts
// it to degrees by repeated subtraction with round-half-up, and watches for
// a missing signal.
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   pwm       raw PWM pin, asynchronous to clk
//   xita      last decoded angle in degrees (bits 31:8 always zero)
//   valid     one-cycle strobe when xita updates
//   range_err last pulse was out of range or stuck high; held until next decode
//   lost      no rising edge for TIMEOUT_CYC cycles; clears on next rising edge
module pwm_capture_ch
  import arm_pkg::*;
#(
  parameter int unsigned DUTY_GAP    = arm_pkg::DUTY_GAP,
  parameter int unsigned OFFSET_CYC  = arm_pkg::OFFSET_CYC,
  parameter int unsigned MAX_DEG     = arm_pkg::MAX_DEG,
  parameter int unsigned TIMEOUT_CYC = arm_pkg::TIMEOUT_CYC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwm,
  output logic [31:0] xita,
  output logic        valid,
  output logic        range_err,
  output logic        lost
);

  localparam int unsigned ToW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [HIGH_CNT_W-1:0] OffsetC  = HIGH_CNT_W'(OFFSET_CYC);
  localparam logic [HIGH_CNT_W-1:0] GapC     = HIGH_CNT_W'(DUTY_GAP);
  localparam logic [HIGH_CNT_W-1:0] HalfGapC = HIGH_CNT_W'(DUTY_GAP / 2);
  localparam logic [HIGH_CNT_W-1:0] TopC     = HIGH_CNT_W'(OFFSET_CYC + MAX_DEG * DUTY_GAP);
  localparam logic [HIGH_CNT_W-1:0] StuckC   =
    HIGH_CNT_W'(OFFSET_CYC + MAX_DEG * DUTY_GAP + DUTY_GAP);
  localparam logic [HIGH_CNT_W-1:0] OneC     = HIGH_CNT_W'(1);
  localparam logic [ANGLE_W-1:0]    MaxDegC  = ANGLE_W'(MAX_DEG);
  localparam logic [ToW-1:0]        TimeoutC = ToW'(TIMEOUT_CYC);

  // ---------------------------------------------------------------------------
  // Input synchronizer and edge detection
  // ---------------------------------------------------------------------------
  logic [1:0] sync_q;
  logic       dly_q;
  logic [1:0] settle_q;
  logic       armed_q;
  logic       pwm_s;
  logic       rise;
  logic       fall;

  // settle_q counts the two cycles it takes for the synchronizer to hold real
  // pin samples after reset. Edges are only honoured once the synchronized
  // pin has been seen low, so a pulse already high at reset release is skipped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      dly_q    <= 1'b0;
      settle_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pwm};
      dly_q  <= sync_q[1];
      if (settle_q != 2'd2) begin
        settle_q <= settle_q + 2'd1;
      end
      if (settle_q == 2'd2 && !sync_q[1]) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign pwm_s = sync_q[1];
  assign rise  = armed_q & pwm_s & ~dly_q;
  assign fall  = armed_q & ~pwm_s & dly_q;

  // ---------------------------------------------------------------------------
  // Loss-of-signal timeout
  // ---------------------------------------------------------------------------
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           lost_q;

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (rise) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TimeoutC) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
      lost_q   <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      lost_q   <= (to_cnt_d == TimeoutC);
    end
  end

  // ---------------------------------------------------------------------------
  // Capture / divide FSM
  // ---------------------------------------------------------------------------
  ch_state_e             state_q;
  logic [HIGH_CNT_W-1:0] high_cnt_q;
  logic [HIGH_CNT_W-1:0] rem_q;
  logic [ANGLE_W-1:0]    quo_q;
  logic [ANGLE_W-1:0]    xita_q;
  logic                  valid_q;
  logic                  rerr_q;

  // Results are registered on the transition into StDone / StStuck, so valid
  // is high exactly during the single StDone cycle (or the first StStuck cycle).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      high_cnt_q <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      xita_q     <= '0;
      valid_q    <= 1'b0;
      rerr_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rise) begin
            high_cnt_q <= OneC;
            state_q    <= StHigh;
          end
        end
        StHigh: begin
          if (fall) begin
            // Wraps when below range; the DIV range checks never use it then.
            rem_q   <= high_cnt_q - OffsetC;
            quo_q   <= '0;
            state_q <= StDiv;
          end else if (high_cnt_q > StuckC) begin
            xita_q  <= MaxDegC;
            rerr_q  <= 1'b1;
            valid_q <= 1'b1;
            state_q <= StStuck;
          end else begin
            high_cnt_q <= high_cnt_q + 1'b1;
          end
        end
        StDiv: begin
          if (high_cnt_q < OffsetC) begin
            xita_q  <= '0;
            rerr_q  <= 1'b1;
            valid_q <= 1'b1;
            state_q <= StDone;
          end else if (high_cnt_q > TopC) begin
            xita_q  <= MaxDegC;
            rerr_q  <= 1'b1;
            valid_q <= 1'b1;
            state_q <= StDone;
          end else if (rem_q >= GapC) begin
            rem_q <= rem_q - GapC;
            quo_q <= quo_q + 1'b1;
          end else begin
            // Round half up, never past full scale.
            if (rem_q >= HalfGapC && quo_q < MaxDegC) begin
              xita_q <= quo_q + 1'b1;
            end else begin
              xita_q <= quo_q;
            end
            rerr_q  <= 1'b0;
            valid_q <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        StStuck: begin
          if (fall) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign xita      = {{(32 - ANGLE_W){1'b0}}, xita_q};
  assign valid     = valid_q;
  assign range_err = rerr_q;
  assign lost      = lost_q;

endmodule

// File: rtl/servo_pwm_decoder.sv
// Two-channel servo PWM decoder.
// Each channel independently converts the high time of its PWM input into an
// angle in degrees; this level only wires two identical capture channels.
// Ports:
//   clk, rst_n               system clock / asynchronous active-low reset
//   pwm1, pwm2               raw servo PWM inputs, asynchronous to clk
//   xita1, xita2             last decoded angles in degrees
//   valid1, valid2           one-cycle update strobes
//   range_err1, range_err2   last pulse out of range or stuck high
//   lost1, lost2             no rising edge within TIMEOUT_CYC cycles
module servo_pwm_decoder
  import arm_pkg::*;
#(
  parameter int unsigned DUTY_GAP    = arm_pkg::DUTY_GAP,
  parameter int unsigned OFFSET_CYC  = arm_pkg::OFFSET_CYC,
  parameter int unsigned MAX_DEG     = arm_pkg::MAX_DEG,
  parameter int unsigned TIMEOUT_CYC = arm_pkg::TIMEOUT_CYC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwm1,
  input  logic        pwm2,
  output logic [31:0] xita1,
  output logic [31:0] xita2,
  output logic        valid1,
  output logic        valid2,
  output logic        range_err1,
  output logic        range_err2,
  output logic        lost1,
  output logic        lost2
);

  pwm_capture_ch #(
    .DUTY_GAP    (DUTY_GAP),
    .OFFSET_CYC  (OFFSET_CYC),
    .MAX_DEG     (MAX_DEG),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_ch1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwm       (pwm1),
    .xita      (xita1),
    .valid     (valid1),
    .range_err (range_err1),
    .lost      (lost1)
  );

  pwm_capture_ch #(
    .DUTY_GAP    (DUTY_GAP),
    .OFFSET_CYC  (OFFSET_CYC),
    .MAX_DEG     (MAX_DEG),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_ch2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwm       (pwm2),
    .xita      (xita2),
    .valid     (valid2),
    .range_err (range_err2),
    .lost      (lost2)
  );

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Self-checking bench for servo_pwm_decoder, run with scaled-down timing so
// the full scenario list fits in a short simulation.
module tb_servo_pwm_decoder;

  localparam int unsigned GAP  = 20;
  localparam int unsigned OFF  = 500;
  localparam int unsigned MAXD = 180;
  localparam int unsigned TO   = 10000;
  localparam int unsigned TOP  = OFF + MAXD * GAP;   // longest in-range pulse
  localparam int unsigned LIM  = TOP + GAP;          // stuck threshold
  localparam int unsigned LAT  = MAXD + 8;           // max fall-to-valid latency

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwm1 = 1'b0;
  logic        pwm2 = 1'b0;
  logic [31:0] xita1, xita2;
  logic        valid1, valid2, range_err1, range_err2, lost1, lost2;

  servo_pwm_decoder #(
    .DUTY_GAP    (GAP),
    .OFFSET_CYC  (OFF),
    .MAX_DEG     (MAXD),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm1       (pwm1),
    .pwm2       (pwm2),
    .xita1      (xita1),
    .xita2      (xita2),
    .valid1     (valid1),
    .valid2     (valid2),
    .range_err1 (range_err1),
    .range_err2 (range_err2),
    .lost1      (lost1),
    .lost2      (lost2)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: counts valid pulses per channel and snapshots outputs.
  int          v_cnt [2] = '{0, 0};
  int          v_cyc [2] = '{0, 0};
  logic [31:0] v_x   [2];
  logic        v_e   [2];
  int          rise_cyc [2] = '{0, 0};
  int          fall_cyc [2] = '{0, 0};

  always @(negedge clk) begin
    if (valid1) begin
      v_cnt[0] <= v_cnt[0] + 1;
      v_x[0]   <= xita1;
      v_e[0]   <= range_err1;
      v_cyc[0] <= cyc;
    end
    if (valid2) begin
      v_cnt[1] <= v_cnt[1] + 1;
      v_x[1]   <= xita2;
      v_e[1]   <= range_err2;
      v_cyc[1] <= cyc;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] xita_of(input int ch);
    return (ch == 1) ? xita1 : xita2;
  endfunction

  function automatic logic rerr_of(input int ch);
    return (ch == 1) ? range_err1 : range_err2;
  endfunction

  // Reference: angle from high time by the decoding rules, in plain arithmetic.
  task automatic ref_model(input int n, output int ang, output logic err);
    int x;
    if (n < int'(OFF)) begin
      ang = 0;
      err = 1'b1;
    end else if (n > int'(TOP)) begin
      ang = MAXD;
      err = 1'b1;
    end else begin
      x   = n - OFF;
      ang = x / GAP;
      if ((x % GAP) >= GAP / 2) ang = ang + 1;
      if (ang > int'(MAXD)) ang = MAXD;
      err = 1'b0;
    end
  endtask

  task automatic set_pin(input int ch, input logic v);
    if (ch == 1) pwm1 = v;
    else pwm2 = v;
  endtask

  // Pin high for exactly n rising clock edges.
  task automatic drive_pulse(input int ch, input int n);
    @(posedge clk);
    #1 set_pin(ch, 1'b1);
    rise_cyc[ch-1] = cyc;
    repeat (n) @(posedge clk);
    #1 set_pin(ch, 1'b0);
    fall_cyc[ch-1] = cyc;
  endtask

  // Waits for the strobe after a pulse of n cycles and checks it.
  task automatic check_decode(input int ch, input int n, input int base, input string tag);
    int   ang;
    logic err;
    bit   got;
    int   lat;
    got = 0;
    ref_model(n, ang, err);
    for (int i = 0; i < int'(LAT) + 4; i++) begin
      @(posedge clk);
      if (v_cnt[ch-1] != base) begin
        got = 1;
        break;
      end
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s strobe: got none, need one within %0d cycles", tag, LAT);
    end else begin
      lat = v_cyc[ch-1] - fall_cyc[ch-1];
      n_tests++;
      if (lat > int'(LAT) || lat < 1) begin
        n_fail++;
        $display("FAIL %s latency: got %0d, need 1..%0d", tag, lat, LAT);
      end
      n_tests++;
      if (v_x[ch-1] !== 32'(ang)) begin
        n_fail++;
        $display("FAIL %s xita: got %0d, need %0d (high %0d)", tag, v_x[ch-1], ang, n);
      end
      n_tests++;
      if (v_e[ch-1] !== err) begin
        n_fail++;
        $display("FAIL %s range_err: got %0b, need %0b (high %0d)", tag, v_e[ch-1], err, n);
      end
      repeat (4) @(posedge clk);
      n_tests++;
      if (v_cnt[ch-1] != base + 1) begin
        n_fail++;
        $display("FAIL %s strobe count: got %0d, need 1", tag, v_cnt[ch-1] - base);
      end
      n_tests++;
      if (xita_of(ch) !== 32'(ang) || rerr_of(ch) !== err) begin
        n_fail++;
        $display("FAIL %s held outputs: got %0d/%0b, need %0d/%0b", tag, xita_of(ch),
                 rerr_of(ch), ang, err);
      end
    end
  endtask

  task automatic pulse_and_check(input int ch, input int n, input string tag);
    int base;
    base = v_cnt[ch-1];
    drive_pulse(ch, n);
    check_decode(ch, n, base, tag);
  endtask

  task automatic check_all_zero(input string tag);
    n_tests++;
    if ({xita1, xita2} !== 64'd0) begin
      n_fail++;
      $display("FAIL %s xita: got %0d/%0d, need 0/0", tag, xita1, xita2);
    end
    n_tests++;
    if ({valid1, valid2, range_err1, range_err2, lost1, lost2} !== 6'b0) begin
      n_fail++;
      $display("FAIL %s flags: got %b, need 000000", tag,
               {valid1, valid2, range_err1, range_err2, lost1, lost2});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_mid_angle();
    pulse_and_check(1, OFF + 90 * GAP, "angle90");
  endtask

  task automatic test_rounding();
    pulse_and_check(2, OFF + GAP / 2 - 1, "round_down");
    pulse_and_check(2, OFF + GAP / 2, "round_up");
    pulse_and_check(2, OFF, "exact_offset");
    pulse_and_check(2, OFF - 1, "just_below");
  endtask

  task automatic test_range();
    pulse_and_check(1, 300, "below_range");
    pulse_and_check(1, TOP, "full_scale");
    pulse_and_check(1, TOP + 1, "just_above");
  endtask

  task automatic test_stuck();
    int base;
    int t;
    base = v_cnt[0];
    @(posedge clk);
    #1 pwm1 = 1'b1;
    rise_cyc[0] = cyc;
    repeat (LIM + 1500) @(posedge clk);
    n_tests++;
    if (v_cnt[0] != base + 1) begin
      n_fail++;
      $display("FAIL stuck strobe count: got %0d, need 1", v_cnt[0] - base);
    end else begin
      t = v_cyc[0] - rise_cyc[0];
      n_tests++;
      if (t < int'(LIM) || t > int'(LIM) + 8) begin
        n_fail++;
        $display("FAIL stuck timing: got %0d cycles after rise, need %0d..%0d", t, LIM, LIM + 8);
      end
      n_tests++;
      if (v_x[0] !== 32'(MAXD) || v_e[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL stuck result: got %0d/%0b, need %0d/1", v_x[0], v_e[0], MAXD);
      end
    end
    #1 pwm1 = 1'b0;
    repeat (LAT + 20) @(posedge clk);
    n_tests++;
    if (v_cnt[0] != base + 1 || range_err1 !== 1'b1) begin
      n_fail++;
      $display("FAIL stuck release: got %0d strobes err %0b, need 1 strobe err 1",
               v_cnt[0] - base, range_err1);
    end
    pulse_and_check(1, OFF + 90 * GAP, "after_stuck");
  endtask

  // A second pulse arriving while the first is being divided is dropped.
  task automatic test_ignore_during_div();
    int base;
    base = v_cnt[0];
    drive_pulse(1, TOP);
    repeat (20) @(posedge clk);
    drive_pulse(1, 30);
    repeat (LAT + 40) @(posedge clk);
    n_tests++;
    if (v_cnt[0] != base + 1 || xita1 !== 32'(MAXD) || range_err1 !== 1'b0) begin
      n_fail++;
      $display("FAIL div_ignore: got %0d strobes xita %0d err %0b, need 1/%0d/0",
               v_cnt[0] - base, xita1, range_err1, MAXD);
    end
  endtask

  task automatic test_loopback();
    fork
      pulse_and_check(1, OFF + 45 * GAP, "loop45");
      pulse_and_check(2, OFF + 135 * GAP, "loop135");
    join
  endtask

  task automatic test_random();
    int n1;
    int n2;
    int d1;
    int d2;
    for (int r = 0; r < 6; r++) begin
      n1 = $urandom_range(TOP + GAP, OFF - 60);
      n2 = $urandom_range(TOP + GAP, OFF - 60);
      d1 = $urandom_range(40, 0);
      d2 = $urandom_range(40, 0);
      fork
        begin
          repeat (d1) @(posedge clk);
          pulse_and_check(1, n1, "rand_ch1");
        end
        begin
          repeat (d2) @(posedge clk);
          pulse_and_check(2, n2, "rand_ch2");
        end
      join
    end
  endtask

  task automatic test_timeout();
    int target;
    pulse_and_check(2, OFF + 90 * GAP, "pre_timeout");
    target = rise_cyc[1] + TO - 30;
    while (cyc < target) @(posedge clk);
    #1;
    n_tests++;
    if (lost2 !== 1'b0) begin
      n_fail++;
      $display("FAIL lost_early: got %0b, need 0", lost2);
    end
    target = rise_cyc[1] + TO + 30;
    while (cyc < target) @(posedge clk);
    #1;
    n_tests++;
    if (lost2 !== 1'b1 || xita2 !== 32'd90) begin
      n_fail++;
      $display("FAIL lost_set: got lost %0b xita %0d, need 1/90", lost2, xita2);
    end
    fork
      pulse_and_check(2, OFF + 10 * GAP, "after_lost");
      begin
        repeat (10) @(posedge clk);
        #1;
        n_tests++;
        if (lost2 !== 1'b0) begin
          n_fail++;
          $display("FAIL lost_clear: got %0b, need 0", lost2);
        end
      end
    join
  endtask

  task automatic test_reset_abort();
    int base;
    base = v_cnt[0];
    // Reset mid-pulse, released while the pin is still high.
    fork
      drive_pulse(1, 2000);
      begin
        repeat (500) @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset_mid_pulse");
        #1 rst_n = 1'b1;
      end
    join
    repeat (LAT + 20) @(posedge clk);
    n_tests++;
    if (v_cnt[0] != base || xita1 !== 32'd0) begin
      n_fail++;
      $display("FAIL stale_pulse: got %0d strobes xita %0d, need 0/0", v_cnt[0] - base, xita1);
    end
    // Reset mid-divide.
    pulse_and_check(1, OFF + 30 * GAP, "pre_div_reset");
    base = v_cnt[0];
    drive_pulse(1, TOP);
    repeat (40) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (LAT + 20) @(posedge clk);
    n_tests++;
    if (v_cnt[0] != base || xita1 !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_div: got %0d strobes xita %0d, need 0/0", v_cnt[0] - base, xita1);
    end
    pulse_and_check(1, OFF + 45 * GAP, "after_reset");
  endtask

  initial begin
    test_reset();
    test_mid_angle();
    test_rounding();
    test_range();
    test_stuck();
    test_ignore_during_div();
    test_loopback();
    test_random();
    test_timeout();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
